// File: rtl/hb_pwm_pkg.sv
// Shared types and width helpers for the multi-leg half-bridge PWM generator.
package hb_pwm_pkg;

  typedef enum logic [1:0] {
    ST_LOW  = 2'd0,
    ST_HIGH = 2'd1,
    ST_DEAD = 2'd2
  } leg_state_e;

  // A DT of 0 still needs a 1-bit counter so the port widths stay legal.
  function automatic int dt_cnt_w(input int dt);
    return (dt < 1) ? 1 : $clog2(dt + 1);
  endfunction

  function automatic int carrier_w(input int period);
    return (period < 2) ? 1 : $clog2(period);
  endfunction

endpackage

// File: rtl/hb_pwm_multi_if.sv
// Control-side and gate-side signals of hb_pwm_multi, bundled with master/slave views.
interface hb_pwm_multi_if #(
  parameter int N_CH = 3,
  parameter int DW   = 10
);
  // No handshake: every input is a level sampled on each rising clk edge,
  // and every output is a registered level (sync is a one-clk pulse).
  logic                 ce;
  logic                 en;
  logic [N_CH*DW-1:0]   d;
  logic                 fault;
  logic                 fault_clr;
  logic [N_CH-1:0]      s;
  logic [N_CH-1:0]      nots;
  logic                 clk_int;
  logic                 sync;
  logic                 faulted;
  logic [2*N_CH-1:0]    dbg_state;

  modport master (
    output ce, en, d, fault, fault_clr,
    input  s, nots, clk_int, sync, faulted, dbg_state
  );

  modport slave (
    input  ce, en, d, fault, fault_clr,
    output s, nots, clk_int, sync, faulted, dbg_state
  );
endinterface

// File: rtl/hb_dt_leg.sv
// One half-bridge leg: dead-time FSM with registered high/low gate outputs.
module hb_dt_leg
  import hb_pwm_pkg::*;
#(
  parameter int DT = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  input  logic       raw,
  input  logic       force_dead,
  output logic       s,
  output logic       nots,
  output leg_state_e state_o
);

  localparam int DTW = dt_cnt_w(DT);
  localparam logic [DTW-1:0] DT_LOAD = DTW'((DT > 0) ? DT - 1 : 0);

  leg_state_e     state_q, state_d;
  logic           target_q, target_d;
  logic [DTW-1:0] dt_cnt_q, dt_cnt_d;
  logic           s_q, s_d;
  logic           nots_q, nots_d;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    dt_cnt_d = dt_cnt_q;
    if (force_dead) begin
      state_d  = ST_DEAD;
      target_d = 1'b0;
      dt_cnt_d = DT_LOAD;
    end else if (ce) begin
      if (raw != target_q) begin
        // Every raw change restarts the full dead-time, even mid-DEAD.
        target_d = raw;
        if (DT == 0) begin
          state_d = raw ? ST_HIGH : ST_LOW;
        end else begin
          state_d  = ST_DEAD;
          dt_cnt_d = DT_LOAD;
        end
      end else if (state_q == ST_DEAD) begin
        if (dt_cnt_q == '0) begin
          state_d = target_q ? ST_HIGH : ST_LOW;
        end else begin
          dt_cnt_d = dt_cnt_q - DTW'(1);
        end
      end
    end
    // Gates decode the next state so they are registered alongside it.
    s_d    = (state_d == ST_HIGH);
    nots_d = (state_d == ST_LOW);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_DEAD;
      target_q <= 1'b0;
      dt_cnt_q <= '0;
      s_q      <= 1'b0;
      nots_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      dt_cnt_q <= dt_cnt_d;
      s_q      <= s_d;
      nots_q   <= nots_d;
    end
  end

  assign s       = s_q;
  assign nots    = nots_q;
  assign state_o = state_q;

endmodule

// File: rtl/hb_pwm_multi.sv
// N-leg half-bridge PWM: shared carrier, shadowed duties, fault latch, interrupt divider,
// and one dead-time leg per channel.
module hb_pwm_multi
  import hb_pwm_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int DW      = 10,
  parameter int PERIOD  = 600,
  parameter int DT      = 30,
  parameter int INT_DIV = 40
) (
  input  logic           clk,
  input  logic           rst,
  hb_pwm_multi_if.slave  bus
);

  localparam int CW = carrier_w(PERIOD);
  localparam int IW = $clog2(INT_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [IW-1:0] INT_LAST = IW'(INT_DIV - 1);
  localparam logic [IW-1:0] INT_HALF = IW'(INT_DIV / 2);

  logic [CW-1:0]              cnt_q, cnt_d;
  logic [N_CH-1:0][DW-1:0]    shadow_q, shadow_d;
  logic [IW-1:0]              int_cnt_q, int_cnt_d;
  logic                       faulted_q, faulted_d;
  logic                       sync_q, sync_d;
  logic                       clk_int_q, clk_int_d;

  logic                       force_dead;
  logic                       wrap;
  logic [N_CH-1:0]            raw;
  logic [N_CH-1:0]            s_w;
  logic [N_CH-1:0]            nots_w;
  logic [2*N_CH-1:0]          dbg_w;

  always_comb begin
    // A fault on this very edge already stops the carrier and forces the legs.
    force_dead = bus.fault | faulted_q | ~bus.en;
    wrap       = ~force_dead & bus.ce & (cnt_q == CNT_LAST);

    cnt_d = cnt_q;
    if (force_dead) begin
      cnt_d = '0;
    end else if (bus.ce) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
    end

    shadow_d = shadow_q;
    for (int i = 0; i < N_CH; i++) begin
      if (!bus.en || wrap) begin
        shadow_d[i] = bus.d[i*DW +: DW];
      end
    end

    int_cnt_d = int_cnt_q;
    if (wrap) begin
      int_cnt_d = (int_cnt_q == INT_LAST) ? '0 : int_cnt_q + IW'(1);
    end

    faulted_d = bus.fault ? 1'b1 : (bus.fault_clr ? 1'b0 : faulted_q);
    sync_d    = wrap;
    clk_int_d = (int_cnt_q < INT_HALF);

    // shadow >= PERIOD keeps raw high across the wrap since cnt never reaches it.
    for (int i = 0; i < N_CH; i++) begin
      raw[i] = (DW'(cnt_q) < shadow_q[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      shadow_q  <= '0;
      int_cnt_q <= '0;
      faulted_q <= 1'b0;
      sync_q    <= 1'b0;
      clk_int_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      shadow_q  <= shadow_d;
      int_cnt_q <= int_cnt_d;
      faulted_q <= faulted_d;
      sync_q    <= sync_d;
      clk_int_q <= clk_int_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_leg
    leg_state_e st;

    hb_dt_leg #(.DT(DT)) u_leg (
      .clk        (clk),
      .rst        (rst),
      .ce         (bus.ce),
      .raw        (raw[i]),
      .force_dead (force_dead),
      .s          (s_w[i]),
      .nots       (nots_w[i]),
      .state_o    (st)
    );

    assign dbg_w[2*i +: 2] = st;
  end

  assign bus.s         = s_w;
  assign bus.nots      = nots_w;
  assign bus.dbg_state = dbg_w;
  assign bus.sync      = sync_q;
  assign bus.clk_int   = clk_int_q;
  assign bus.faulted   = faulted_q;

endmodule

// File: tb/tb_hb_pwm_multi.sv
// Directed and randomized checks of hb_pwm_multi against a run-length reference model.
module tb_hb_pwm_multi;
  import hb_pwm_pkg::*;

  localparam int N_CH    = 3;
  localparam int DW      = 4;
  localparam int PERIOD  = 10;
  localparam int DT      = 2;
  localparam int INT_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  hb_pwm_multi_if #(.N_CH(N_CH), .DW(DW)) bus ();

  hb_pwm_multi #(
    .N_CH(N_CH), .DW(DW), .PERIOD(PERIOD), .DT(DT), .INT_DIV(INT_DIV)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: carrier/shadow by arithmetic, legs by "level must persist DT+1 ticks".
  int              dv       [N_CH];
  int              m_cnt;
  int              m_shadow [N_CH];
  bit              m_faulted;
  int              m_wraps;
  bit              m_sync;
  bit              m_clk_int;
  bit              m_val    [N_CH];
  int              m_len    [N_CH];
  logic [N_CH-1:0] m_s;
  logic [N_CH-1:0] m_nots;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_d();
    for (int i = 0; i < N_CH; i++) bus.d[i*DW +: DW] = DW'(dv[i]);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_faulted = 0; m_wraps = 0; m_sync = 0; m_clk_int = 0;
    m_s = '0; m_nots = '0;
    for (int i = 0; i < N_CH; i++) begin
      m_shadow[i] = 0;
      m_val[i]    = 0;
      m_len[i]    = DT;
    end
  endtask

  task automatic model_edge();
    bit frc, wrap;
    bit raw [N_CH];
    if (rst) begin
      model_reset();
      return;
    end
    frc  = bus.fault || m_faulted || !bus.en;
    wrap = !frc && bus.ce && (m_cnt == PERIOD - 1);
    for (int i = 0; i < N_CH; i++) raw[i] = (m_cnt < m_shadow[i]);
    m_clk_int = ((m_wraps % INT_DIV) < INT_DIV / 2);
    m_sync    = wrap;
    for (int i = 0; i < N_CH; i++) begin
      if (frc) begin
        m_val[i] = 0; m_len[i] = 1; m_s[i] = 0; m_nots[i] = 0;
      end else if (bus.ce) begin
        if (raw[i] == m_val[i]) m_len[i] = (m_len[i] > DT) ? DT + 1 : m_len[i] + 1;
        else begin m_val[i] = raw[i]; m_len[i] = 1; end
        m_s[i]    = (m_len[i] >= DT + 1) &&  m_val[i];
        m_nots[i] = (m_len[i] >= DT + 1) && !m_val[i];
      end
      if (!bus.en || wrap) m_shadow[i] = dv[i];
    end
    if (frc) m_cnt = 0;
    else if (bus.ce) m_cnt = wrap ? 0 : m_cnt + 1;
    if (wrap) m_wraps++;
    m_faulted = bus.fault ? 1'b1 : (bus.fault_clr ? 1'b0 : m_faulted);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("s",       32'(bus.s),            32'(m_s));
    check("nots",    32'(bus.nots),         32'(m_nots));
    check("sync",    32'(bus.sync),         32'(m_sync));
    check("clk_int", 32'(bus.clk_int),      32'(m_clk_int));
    check("faulted", 32'(bus.faulted),      32'(m_faulted));
    check("overlap", 32'(bus.s & bus.nots), 32'(0));
  endtask

  task automatic run_count(input int n, output int s0, output int n0, output int sy,
                           output int s2, output int n1);
    s0 = 0; n0 = 0; sy = 0; s2 = 0; n1 = 0;
    for (int k = 0; k < n; k++) begin
      step();
      s0 += int'(bus.s[0]); n0 += int'(bus.nots[0]); sy += int'(bus.sync);
      s2 += int'(bus.s[2]); n1 += int'(bus.nots[1]);
    end
  endtask

  task automatic wait_cnt(input int target, input string tag);
    int k;
    for (k = 0; k < 40 && m_cnt != target; k++) step();
    check(tag, 32'(m_cnt == target), 32'(1));
  endtask

  // Measures one high and one low phase of clk_int, starting from a rising edge.
  task automatic measure_clk_int(input bit toggle_ce, output int hi, output int lo);
    bit prev, found;
    found = 0; hi = 0; lo = 0;
    prev = bus.clk_int;
    for (int k = 0; k < 400 && !found; k++) begin
      if (toggle_ce) bus.ce = ~bus.ce;
      step();
      found = !prev && bus.clk_int;
      prev  = bus.clk_int;
    end
    check("clk_int_rise_seen", 32'(found), 32'(1));
    for (int k = 0; k < 200 && bus.clk_int; k++) begin
      hi++;
      if (toggle_ce) bus.ce = ~bus.ce;
      step();
    end
    for (int k = 0; k < 200 && !bus.clk_int; k++) begin
      lo++;
      if (toggle_ce) bus.ce = ~bus.ce;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n0, sy, s2, n1, hi, lo, first_any, first_s0;
    bit found;

    bus.ce = 0; bus.en = 0; bus.d = '0; bus.fault = 0; bus.fault_clr = 0;
    for (int i = 0; i < N_CH; i++) dv[i] = 0;
    model_reset();

    // Reset values, observed before any clock edge.
    #1 rst = 1'b1;
    #1;
    check("rst_s",       32'(bus.s),         32'(0));
    check("rst_nots",    32'(bus.nots),      32'(0));
    check("rst_sync",    32'(bus.sync),      32'(0));
    check("rst_clk_int", 32'(bus.clk_int),   32'(0));
    check("rst_faulted", 32'(bus.faulted),   32'(0));
    check("rst_state",   32'(bus.dbg_state), 32'({ST_DEAD, ST_DEAD, ST_DEAD}));
    repeat (2) step();

    // Steady PWM with clamped channels: d0=5, d1=0, d2=12.
    rst = 1'b0;
    dv[0] = 5; dv[1] = 0; dv[2] = 12;
    apply_d();
    bus.ce = 1;
    repeat (3) step();
    bus.en = 1;
    repeat (30) step();
    run_count(PERIOD, s0, n0, sy, s2, n1);
    check("steady_s0_high",   32'(s0), 32'(5 - DT));
    check("steady_nots0_high", 32'(n0), 32'(PERIOD - 5 - DT));
    check("steady_sync_count", 32'(sy), 32'(1));
    check("clamp_s2_high",    32'(s2), 32'(PERIOD));
    check("clamp_nots1_high", 32'(n1), 32'(PERIOD));

    // Shadow update in mid-period: current period unaffected, next one uses 8.
    wait_cnt(3, "wait_cnt3");
    dv[0] = 8;
    apply_d();
    repeat (PERIOD) step();
    run_count(PERIOD, s0, n0, sy, s2, n1);
    check("shadow_s0_high",    32'(s0), 32'(8 - DT));
    check("shadow_nots0_high", 32'(n0), 32'(0));
    dv[0] = 5;
    apply_d();
    repeat (2 * PERIOD) step();

    // Fault latch, clear priority and restart.
    wait_cnt(2, "wait_cnt2");
    bus.fault = 1;
    step();
    check("fault_gates_s",    32'(bus.s),       32'(0));
    check("fault_gates_nots", 32'(bus.nots),    32'(0));
    check("fault_flag",       32'(bus.faulted), 32'(1));
    bus.fault_clr = 1;
    step();
    check("fault_wins_clr", 32'(bus.faulted), 32'(1));
    bus.fault = 0; bus.fault_clr = 0;
    repeat (3) step();
    check("fault_latched", 32'(bus.faulted), 32'(1));
    bus.fault_clr = 1;
    step();
    bus.fault_clr = 0;
    check("fault_cleared", 32'(bus.faulted), 32'(0));
    first_any = 0; first_s0 = 0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (first_any == 0 && (|bus.s || |bus.nots)) first_any = k;
      if (first_s0 == 0 && bus.s[0]) first_s0 = k;
    end
    check("restart_first_gate", 32'(first_any), 32'(DT));
    check("restart_s0_rise",    32'(first_s0),  32'(DT + 1));

    // Interrupt divider: 20/20 with ce=1, 40/40 with ce every other clk.
    measure_clk_int(1'b0, hi, lo);
    check("clk_int_high", 32'(hi), 32'(INT_DIV / 2 * PERIOD));
    check("clk_int_low",  32'(lo), 32'(INT_DIV / 2 * PERIOD));
    measure_clk_int(1'b1, hi, lo);
    check("clk_int_high_half_ce", 32'(hi), 32'(INT_DIV * PERIOD));
    check("clk_int_low_half_ce",  32'(lo), 32'(INT_DIV * PERIOD));

    // Randomized traffic: ce gaps, duty changes, en drops, faults and clears.
    for (int k = 0; k < 400; k++) begin
      bus.ce        = ($urandom_range(0, 3) != 0);
      bus.en        = ($urandom_range(0, 19) != 0);
      bus.fault     = ($urandom_range(0, 39) == 0);
      bus.fault_clr = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N_CH; i++)
        if ($urandom_range(0, 15) == 0) dv[i] = $urandom_range(0, 15);
      apply_d();
      step();
    end

    // Asynchronous reset while s[0] is high.
    bus.ce = 1; bus.en = 1; bus.fault = 0; bus.fault_clr = 1;
    dv[0] = 5;
    apply_d();
    step();
    bus.fault_clr = 0;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      step();
      found = bus.s[0];
    end
    check("arst_s0_seen_high", 32'(found), 32'(1));
    #2 rst = 1'b1;
    #1;
    check("arst_s",       32'(bus.s),       32'(0));
    check("arst_nots",    32'(bus.nots),    32'(0));
    check("arst_sync",    32'(bus.sync),    32'(0));
    check("arst_clk_int", 32'(bus.clk_int), 32'(0));
    check("arst_faulted", 32'(bus.faulted), 32'(0));
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    repeat (3 * PERIOD) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
